adc128s_model: RTL and testbench
================================

Name: adc128s_model

Overview:
- Behavioural/synthesizable model of a TI ADC128S-style 8-channel, 12-bit SPI A/D converter.
- Used in the Segway system bench. It serves the DUT's A2D interface (left/right load cells, battery) with values the bench drives through the *_set inputs.
- Internally sampled on the system clock: SPI pins are oversampled, not used as clocks.
- A frame returns the conversion of the channel selected in the previous frame (ADC128S pipelined protocol).

Parameters:
- CH_LFT, 3'd0, channel that returns lft_cell_set.
- CH_RGHT, 3'd4, channel that returns rght_cell_set.
- CH_BATT, 3'd5, channel that returns batt_set.
- FRAME_BITS, 16, SCLK cycles per frame.

Ports:
- clk, input, 1, system clock; all state on posedge.
- rst_n, input, 1, reset: asynchronous, active-low.
- SS_n, input, 1, active-low slave select from the SPI master.
- SCLK, input, 1, serial clock from the master. May idle high or low. Half-period ≥ 4 clk.
- MOSI, input, 1, command bits, MSB first.
- MISO, output, 1, result bits, MSB first.
- lft_cell_set, input, 12, value converted on CH_LFT.
- rght_cell_set, input, 12, value converted on CH_RGHT.
- batt_set, input, 12, value converted on CH_BATT.

Behaviour:
- Synchronisers and edge detects:
  - SS_n, SCLK and MOSI each pass through a 2-flop synchroniser (reset: SS_n=1, SCLK=1, MOSI=0).
  - SCLK rise = ff1 & ~ff2; SCLK fall = ~ff1 & ff2.
  - SS_n fall and SS_n rise are detected the same way.
- Frame start (SS_n fall detected):
  - tx_shift[15:0] <= {4'b0000, sel_data}. sel_data is the *_set value of the channel held in chan_ptr, latched at this instant.
  - Any channel other than CH_LFT, CH_RGHT or CH_BATT returns 12'h000.
  - Clear bit_cnt and the seen_rise flag.
- During a frame (synchronised SS_n low):
  - On each SCLK rise: rx_shift <= {rx_shift[14:0], MOSI_sync}; bit_cnt++ (saturates at 31); seen_rise <= 1.
  - On each SCLK fall with seen_rise=1: tx_shift <= {tx_shift[14:0], 1'b0}.
  - A fall before the first rise is ignored, so bit 15 is not lost when SCLK idles high.
- MISO = tx_shift[15] while SS_n is low, and 1'b0 while SS_n is high. It is a registered source, so it is glitch-free.
- Frame end (SS_n rise detected):
  - If bit_cnt == FRAME_BITS: chan_ptr <= rx_shift[13:11].
  - Otherwise the frame is treated as aborted and chan_ptr is unchanged.
  - rx_shift[15:14] and rx_shift[10:0] are don't-care.
- Reset values: chan_ptr=0, tx_shift=0, rx_shift=0, bit_cnt=0, seen_rise=0, MISO=0.
- Reset asserted mid-frame: all state returns to reset values immediately. The frame in progress is discarded, and the next frame returns channel 0.
- Latency:
  - Data for channel N appears on MISO in the frame after the frame whose command carried N.
  - The first frame after reset returns channel 0 (lft_cell_set).
- *_set inputs changing mid-frame do not affect the frame in progress.
- Back-to-back frames need SS_n high for ≥ 3 clk so both edges are detected.

Decomposition:
- Shared package (segway_pkg): channel constants CH_LFT/CH_RGHT/CH_BATT and FRAME_BITS, so the DUT's A2D interface and this model agree.
- One natural sub-module: spi_edge_sync. It provides the 2-flop synchroniser plus rise/fall pulse generator, instantiated for SS_n and SCLK. MOSI uses the synchroniser only.

Test Plan:
- Reset, then send one 16-bit frame with any command and lft_cell_set=12'h130 → MISO reads 16'h0130.
- Frame with cmd 16'h2000 (ch4), then a second frame with rght_cell_set=12'h0A5 → second frame returns 16'h00A5.
- Frame with cmd 16'h2800 (ch5), then a frame with batt_set=12'hFFF → returns 16'h0FFF. Set batt_set=12'h800 mid-frame → that frame still returns 16'h0FFF, and the next ch5 frame returns 16'h0800.
- Frame with cmd 16'h1000 (ch2), then another frame → returns 16'h0000.
- Select ch4 in a complete frame, then abort the next frame after 8 SCLK cycles by raising SS_n → the following full frame still returns rght_cell_set.
- Assert rst_n low mid-frame after selecting ch5 → MISO=0 immediately, and the next frame returns lft_cell_set. Repeat the scenarios with SCLK idling high and idling low → identical results.

Source files
------------

// File: rtl/segway_pkg.sv
// segway_pkg: constants shared by the Segway A2D interface and the ADC
// model, so both sides agree on the channel map and the frame length.
//   CH_LFT / CH_RGHT / CH_BATT : channel numbers of the three sensors
//   FRAME_BITS                 : SCLK cycles in one full SPI frame
//   BIT_CNT_W                  : width of the frame bit counter
//   select_sample()            : maps a channel number to its 12-bit value
package segway_pkg;

   localparam logic [2:0] CH_LFT     = 3'd0;
   localparam logic [2:0] CH_RGHT    = 3'd4;
   localparam logic [2:0] CH_BATT    = 3'd5;
   localparam int         FRAME_BITS = 16;
   localparam int         BIT_CNT_W  = 5;

   // Channels without a sensor attached convert to zero.
   function automatic logic [11:0] select_sample(
      input logic [2:0]  ch,
      input logic [11:0] lft,
      input logic [11:0] rght,
      input logic [11:0] batt
   );
      logic [11:0] val;
      val = 12'h000;
      case (ch)
         CH_LFT:  val = lft;
         CH_RGHT: val = rght;
         CH_BATT: val = batt;
         default: val = 12'h000;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-flop synchroniser for an asynchronous SPI pin plus
// single-cycle rise/fall pulses derived from the two stages.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (both stages load RST_VAL)
//   din   : asynchronous input pin
//   sync  : synchronised level (second stage)
//   rise  : one-clk pulse, first stage 1 while second stage 0
//   fall  : one-clk pulse, first stage 0 while second stage 1
module spi_edge_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic ff1_reg;
   logic ff2_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff1_reg <= RST_VAL;
         ff2_reg <= RST_VAL;
      end else begin
         ff1_reg <= din;
         ff2_reg <= ff1_reg;
      end
   end

   assign sync = ff2_reg;
   assign rise = ff1_reg & ~ff2_reg;
   assign fall = ~ff1_reg & ff2_reg;

endmodule

// File: rtl/adc128s_model.sv
// adc128s_model: model of an ADC128S-style 8-channel 12-bit SPI A/D converter.
// SPI pins are oversampled on clk. Each frame returns the value of the
// channel selected by the command of the previous complete frame.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   SS_n, SCLK, MOSI: SPI inputs from the master (asynchronous)
//   MISO            : registered result bit, MSB first, 0 while SS_n high
//   lft_cell_set    : value returned on CH_LFT
//   rght_cell_set   : value returned on CH_RGHT
//   batt_set        : value returned on CH_BATT
module adc128s_model
   import segway_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [11:0] lft_cell_set,
   input  logic [11:0] rght_cell_set,
   input  logic [11:0] batt_set
);

   logic ss_sync, ss_rise, ss_fall;
   logic sclk_rise, sclk_fall;
   logic sclk_sync_unused;
   logic mosi_ff1_reg, mosi_sync_reg;

   spi_edge_sync #(.RST_VAL(1'b1)) u_ss_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (SS_n),
      .sync  (ss_sync),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

   spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (SCLK),
      .sync  (sclk_sync_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   // MOSI only needs a level; it is stable around every SCLK rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mosi_ff1_reg  <= 1'b0;
         mosi_sync_reg <= 1'b0;
      end else begin
         mosi_ff1_reg  <= MOSI;
         mosi_sync_reg <= mosi_ff1_reg;
      end
   end

   // Only command bits [13:11] matter, so the receive shifter keeps just
   // the low 14 bits of the frame; bits [15:14] fall off the top.
   logic [2:0]           chan_ptr_reg,  chan_ptr_next;
   logic [15:0]          tx_shift_reg,  tx_shift_next;
   logic [13:0]          rx_shift_reg,  rx_shift_next;
   logic [BIT_CNT_W-1:0] bit_cnt_reg,   bit_cnt_next;
   logic                 seen_rise_reg, seen_rise_next;
   logic                 miso_reg,      miso_next;
   logic                 ss_low_next;

   always_comb begin
      chan_ptr_next  = chan_ptr_reg;
      tx_shift_next  = tx_shift_reg;
      rx_shift_next  = rx_shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      seen_rise_next = seen_rise_reg;

      if (ss_fall) begin
         tx_shift_next  = {4'b0000, select_sample(chan_ptr_reg, lft_cell_set,
                                                  rght_cell_set, batt_set)};
         bit_cnt_next   = '0;
         seen_rise_next = 1'b0;
      end else if (ss_rise) begin
         // Only a frame of exactly FRAME_BITS clocks updates the pointer.
         if (bit_cnt_reg == BIT_CNT_W'(FRAME_BITS))
            chan_ptr_next = rx_shift_reg[13:11];
      end else if (!ss_sync) begin
         if (sclk_rise) begin
            rx_shift_next  = {rx_shift_reg[12:0], mosi_sync_reg};
            seen_rise_next = 1'b1;
            if (bit_cnt_reg != {BIT_CNT_W{1'b1}})
               bit_cnt_next = bit_cnt_reg + 1'b1;
         end
         // A fall before the first rise is the idle-high leading edge.
         if (sclk_fall && seen_rise_reg)
            tx_shift_next = {tx_shift_reg[14:0], 1'b0};
      end

      // Level the synchronised SS_n takes on after this clock.
      ss_low_next = ss_fall | (~ss_sync & ~ss_rise);
      miso_next   = ss_low_next ? tx_shift_next[15] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chan_ptr_reg  <= 3'd0;
         tx_shift_reg  <= 16'h0000;
         rx_shift_reg  <= 14'h0000;
         bit_cnt_reg   <= '0;
         seen_rise_reg <= 1'b0;
         miso_reg      <= 1'b0;
      end else begin
         chan_ptr_reg  <= chan_ptr_next;
         tx_shift_reg  <= tx_shift_next;
         rx_shift_reg  <= rx_shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         seen_rise_reg <= seen_rise_next;
         miso_reg      <= miso_next;
      end
   end

   assign MISO = miso_reg;

endmodule

// File: tb/tb_adc128s_model.sv
// tb_adc128s_model: drives SPI frames into adc128s_model in both SCLK idle
// polarities and compares each returned word with a channel-pointer model.
module tb_adc128s_model;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic [11:0] lft_cell_set;
   logic [11:0] rght_cell_set;
   logic [11:0] batt_set;

   int   errors = 0;
   int   checks = 0;
   bit   idle_high;
   int   model_ptr;
   bit   chg_en;
   logic [11:0] chg_val;
   logic [15:0] rx_word;

   adc128s_model dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .SS_n          (SS_n),
      .SCLK          (SCLK),
      .MOSI          (MOSI),
      .MISO          (MISO),
      .lft_cell_set  (lft_cell_set),
      .rght_cell_set (rght_cell_set),
      .batt_set      (batt_set)
   );

   always #5 clk = ~clk;

   // Reference: word returned for a channel given the current sensor values.
   function automatic logic [15:0] model_word(input int ch);
      case (ch)
         0:       return {4'h0, lft_cell_set};
         4:       return {4'h0, rght_cell_set};
         5:       return {4'h0, batt_set};
         default: return 16'h0000;
      endcase
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h idle_high=%0d", tag, obs, exp, idle_high);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hard_reset();
      SS_n = 1'b1;
      SCLK = idle_high;
      MOSI = 1'b0;
      rst_n = 1'b0;
      clks(2);
      check("reset_miso", {15'h0, MISO}, 16'h0000);
      rst_n = 1'b1;
      model_ptr = 0;
      clks(4);
   endtask

   // One SPI frame with nrise SCLK rises; optionally reset mid-frame.
   task automatic do_frame(input string tag, input logic [15:0] cmd,
                           input int nrise, input bit rst_mid);
      logic [15:0] exp;
      int          idx;
      exp     = model_word(model_ptr);
      rx_word = 16'h0000;
      SS_n    = 1'b0;
      clks(8);
      for (int i = 0; i < nrise; i++) begin
         if (idle_high) SCLK = 1'b0;
         MOSI = (i < 16) ? cmd[15-i] : 1'b0;
         clks(6);
         if (i < 16) rx_word[15-i] = MISO;
         SCLK = 1'b1;
         clks(6);
         if (!idle_high) SCLK = 1'b0;
         if (chg_en && i == 7) batt_set = chg_val;
      end
      if (rst_mid) begin
         idx = idle_high ? 16 - nrise : 15 - nrise;
         check({tag, "_pre_rst_miso"}, {15'h0, MISO}, {15'h0, exp[idx]});
         rst_n = 1'b0;
         #1;
         check({tag, "_rst_miso"}, {15'h0, MISO}, 16'h0000);
         clks(2);
         SS_n = 1'b1;
         SCLK = idle_high;
         MOSI = 1'b0;
         clks(2);
         rst_n = 1'b1;
         clks(4);
         model_ptr = 0;
      end else begin
         clks(6);
         SS_n = 1'b1;
         clks(6);
         check({tag, "_miso_idle"}, {15'h0, MISO}, 16'h0000);
         if (nrise == 16) begin
            check(tag, rx_word, exp);
            model_ptr = int'(cmd[13:11]);
         end
      end
      $display("frame %-10s idle_high=%0d cmd=%h rises=%0d rx=%h exp=%h", tag,
               idle_high, cmd, nrise, rx_word, exp);
   endtask

   initial begin
      rst_n         = 1'b0;
      SS_n          = 1'b1;
      SCLK          = 1'b1;
      MOSI          = 1'b0;
      lft_cell_set  = 12'h000;
      rght_cell_set = 12'h000;
      batt_set      = 12'h000;
      chg_en        = 1'b0;
      chg_val       = 12'h000;
      model_ptr     = 0;

      for (int pass = 0; pass < 2; pass++) begin
         idle_high = (pass == 1);
         hard_reset();

         // First frame after reset returns channel 0.
         lft_cell_set = 12'h130;
         do_frame("first", 16'(($urandom & 32'h0000_FFFF)), 16, 1'b0);

         // Channel 4 selection.
         do_frame("sel4", 16'h2000, 16, 1'b0);
         rght_cell_set = 12'h0A5;
         do_frame("rght", 16'h2800, 16, 1'b0);

         // Channel 5 with a mid-frame change of batt_set.
         batt_set = 12'hFFF;
         chg_en   = 1'b1;
         chg_val  = 12'h800;
         do_frame("batt_chg", 16'h2800, 16, 1'b0);
         chg_en   = 1'b0;
         do_frame("batt_new", 16'h1000, 16, 1'b0);

         // Unused channel 2 returns zero.
         do_frame("unused2", 16'h2000, 16, 1'b0);

         // Aborted frames (short and over-long) keep the pointer.
         rght_cell_set = 12'h5C3;
         do_frame("abort8", 16'h0800, 8, 1'b0);
         do_frame("abort20", 16'h0800, 20, 1'b0);
         do_frame("abort15", 16'h0800, 15, 1'b0);
         do_frame("after_ab", 16'h2800, 16, 1'b0);

         // Mid-frame reset after selecting ch5.
         batt_set = 12'hFFF;
         do_frame("rst_frame", 16'h0000, 8, 1'b1);
         lft_cell_set = 12'h3AB;
         do_frame("after_rst", 16'h2800, 16, 1'b0);

         // Randomized frames.
         for (int k = 0; k < 8; k++) begin
            lft_cell_set  = 12'($urandom_range(0, 4095));
            rght_cell_set = 12'($urandom_range(0, 4095));
            batt_set      = 12'($urandom_range(0, 4095));
            do_frame("random", 16'(($urandom & 32'h0000_FFFF)), 16, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
